// File: rtl/dma_fifo_pkg.sv
// Shared constants and types for the 8 x 32-bit byte-addressable DMA FIFO.
// Byte lanes are big-endian: lane 0 is bits 31:24 and lane 3 is bits 7:0.
package dma_fifo_pkg;

  localparam int FIFO_DEPTH = 8;
  localparam int PTR_W      = 3;
  localparam int CNT_W      = 4;
  localparam int WORD_W     = 32;
  localparam int BYTE_W     = 8;
  localparam int LANES      = 4;
  localparam int BO_W       = 2;

  localparam logic [BO_W-1:0]  LANE_FIRST = 2'd0;
  localparam logic [BO_W-1:0]  LANE_LAST  = 2'd3;
  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(FIFO_DEPTH);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [BO_W-1:0]  lane_t;

  typedef struct packed {
    ptr_t              addr;
    logic [LANES-1:0]  be;    // be[i] enables bits i*8 +: 8
    logic [WORD_W-1:0] data;
  } ram_wr_t;

  function automatic logic [BYTE_W-1:0] lane_byte(input logic [WORD_W-1:0] word,
                                                  input lane_t lane);
    lane_byte = word[(LANES - 1 - int'(lane)) * BYTE_W +: BYTE_W];
  endfunction

  function automatic logic [LANES-1:0] lane_enable(input lane_t lane);
    lane_enable = 4'b1000 >> lane;
  endfunction

endpackage

// File: rtl/dma_fifo_ram.sv
// 8 x 32 FIFO storage: one byte-wide memory per lane, synchronous write,
// asynchronous read. No reset so it can map onto distributed memory.
module fifo_ram
  import dma_fifo_pkg::*;
(
  input  logic              CLK,
  input  ram_wr_t           wr,
  input  ptr_t              rd_addr,
  output logic [WORD_W-1:0] rd_data
);

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [BYTE_W-1:0] lane_mem [FIFO_DEPTH];

      always_ff @(posedge CLK) begin
        if (wr.be[gi]) begin
          lane_mem[wr.addr] <= wr.data[gi*BYTE_W +: BYTE_W];
        end
      end

      assign rd_data[gi*BYTE_W +: BYTE_W] = lane_mem[rd_addr];
    end
  endgenerate

endmodule

// File: rtl/dma_fifo.sv
// DMA longword FIFO between a byte-serial SCSI side and a 32-bit host side:
// pointer, byte-pointer and occupancy control around the fifo_ram storage.
module dma_fifo
  import dma_fifo_pkg::*;
(
  input  logic              CLK,
  input  logic              nRESET,
  input  logic              FLUSH,
  input  logic              INCBO,
  input  logic              INCNI,
  input  logic              INCNO,
  input  logic              RIFIFO,
  input  logic              RDFIFO,
  input  logic              BWR,
  input  logic [BYTE_W-1:0] SD_IN,
  output logic [BYTE_W-1:0] SD_OUT,
  input  logic              H_WR,
  input  logic              H_RD,
  input  logic [WORD_W-1:0] H_DIN,
  output logic [WORD_W-1:0] H_DOUT,
  output logic              BOEQ3,
  output logic              FIFOFULL,
  output logic              FIFOEMPTY
);

  ptr_t    ni_reg, ni_next;
  ptr_t    no_reg, no_next;
  lane_t   bo_reg, bo_next;
  cnt_t    count_reg, count_next;
  logic    inc_req, dec_req, inc_ok, dec_ok;
  logic    host_wr, host_rd;
  ram_wr_t ram_wr;
  logic [WORD_W-1:0] rd_word;

  always_comb begin
    inc_req = RIFIFO | H_WR;
    dec_req = RDFIFO | H_RD;
    // An opposite request in the same cycle frees or fills the slot, so the
    // full/empty limits only block a lone increment or decrement.
    inc_ok  = inc_req & ((count_reg != CNT_FULL) | dec_req);
    dec_ok  = dec_req & ((count_reg != '0) | inc_req);
    host_wr = H_WR & inc_ok & ~FLUSH;
    host_rd = H_RD & dec_ok;

    ni_next    = ni_reg + ptr_t'(INCNI | host_wr);
    no_next    = no_reg + ptr_t'(INCNO | host_rd);
    bo_next    = bo_reg + lane_t'(INCBO);
    count_next = count_reg;
    if (inc_ok && !dec_ok) begin
      count_next = count_reg + cnt_t'(1);
    end else if (dec_ok && !inc_ok) begin
      count_next = count_reg - cnt_t'(1);
    end

    ram_wr      = '0;
    ram_wr.addr = ni_reg;
    if (host_wr) begin
      ram_wr.be   = '1;
      ram_wr.data = H_DIN;
    end else if (BWR && !H_WR && !FLUSH) begin
      ram_wr.be   = lane_enable(bo_reg);
      ram_wr.data = {LANES{SD_IN}};
    end

    if (FLUSH) begin
      ni_next    = '0;
      no_next    = '0;
      bo_next    = '0;
      count_next = '0;
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      ni_reg    <= '0;
      no_reg    <= '0;
      bo_reg    <= '0;
      count_reg <= '0;
    end else begin
      ni_reg    <= ni_next;
      no_reg    <= no_next;
      bo_reg    <= bo_next;
      count_reg <= count_next;
    end
  end

  fifo_ram u_ram (
    .CLK     (CLK),
    .wr      (ram_wr),
    .rd_addr (no_reg),
    .rd_data (rd_word)
  );

  assign H_DOUT    = rd_word;
  assign SD_OUT    = lane_byte(rd_word, bo_reg);
  assign BOEQ3     = (bo_reg == LANE_LAST);
  assign FIFOFULL  = (count_reg == CNT_FULL);
  assign FIFOEMPTY = (count_reg == '0);

endmodule

// File: tb/tb_dma_fifo.sv
// Directed bench for dma_fifo: a word/lane-level model checked every cycle
// plus hand-computed expectations for each scenario.
module tb_dma_fifo;

  logic        CLK = 1'b0;
  logic        nRESET = 1'b0;
  logic        FLUSH, INCBO, INCNI, INCNO, RIFIFO, RDFIFO, BWR, H_WR, H_RD;
  logic [7:0]  SD_IN, SD_OUT;
  logic [31:0] H_DIN, H_DOUT;
  logic        BOEQ3, FIFOFULL, FIFOEMPTY;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  dma_fifo dut (
    .CLK(CLK), .nRESET(nRESET), .FLUSH(FLUSH), .INCBO(INCBO), .INCNI(INCNI),
    .INCNO(INCNO), .RIFIFO(RIFIFO), .RDFIFO(RDFIFO), .BWR(BWR), .SD_IN(SD_IN),
    .SD_OUT(SD_OUT), .H_WR(H_WR), .H_RD(H_RD), .H_DIN(H_DIN), .H_DOUT(H_DOUT),
    .BOEQ3(BOEQ3), .FIFOFULL(FIFOFULL), .FIFOEMPTY(FIFOEMPTY)
  );

  // ---------------- behavioural model ----------------
  int          m_ni = 0, m_no = 0, m_bo = 0, m_cnt = 0;
  logic [31:0] m_mem   [8];
  logic [3:0]  m_known [8];   // bit l set when lane l of the word holds known data

  wire m_inc    = RIFIFO || H_WR;
  wire m_dec    = RDFIFO || H_RD;
  wire m_inc_ok = m_inc && (m_cnt < 8 || m_dec);
  wire m_dec_ok = m_dec && (m_cnt > 0 || m_inc);
  wire m_hw_ok  = H_WR && m_inc_ok;
  wire m_hr_ok  = H_RD && m_dec_ok;

  always @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      m_ni  <= 0;
      m_no  <= 0;
      m_bo  <= 0;
      m_cnt <= 0;
      for (int w = 0; w < 8; w++) m_known[w] <= 4'h0;
    end else if (FLUSH) begin
      m_ni  <= 0;
      m_no  <= 0;
      m_bo  <= 0;
      m_cnt <= 0;
    end else begin
      if (m_hw_ok) begin
        m_mem[m_ni]   <= H_DIN;
        m_known[m_ni] <= 4'hF;
      end else if (BWR && !H_WR) begin
        m_mem[m_ni][8*(3-m_bo) +: 8] <= SD_IN;
        m_known[m_ni][m_bo]          <= 1'b1;
      end
      m_ni  <= (m_ni + ((INCNI || m_hw_ok) ? 1 : 0)) % 8;
      m_no  <= (m_no + ((INCNO || m_hr_ok) ? 1 : 0)) % 8;
      m_bo  <= (m_bo + (INCBO ? 1 : 0)) % 4;
      m_cnt <= m_cnt + (m_inc_ok ? 1 : 0) - (m_dec_ok ? 1 : 0);
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge CLK) begin
    cmp("FIFOEMPTY", 32'(FIFOEMPTY), 32'(m_cnt == 0));
    cmp("FIFOFULL", 32'(FIFOFULL), 32'(m_cnt == 8));
    cmp("BOEQ3", 32'(BOEQ3), 32'(m_bo == 3));
    cmp("NI", 32'(dut.ni_reg), 32'(m_ni));
    cmp("NO", 32'(dut.no_reg), 32'(m_no));
    cmp("BO", 32'(dut.bo_reg), 32'(m_bo));
    cmp("COUNT", 32'(dut.count_reg), 32'(m_cnt));
    if (m_known[m_no] == 4'hF) cmp("H_DOUT", H_DOUT, m_mem[m_no]);
    if (m_known[m_no][m_bo] === 1'b1) cmp("SD_OUT", 32'(SD_OUT), 32'(m_mem[m_no][8*(3-m_bo) +: 8]));
  end

  // ---------------- directed stimulus ----------------
  task automatic clear_inputs();
    FLUSH = 0; INCBO = 0; INCNI = 0; INCNO = 0; RIFIFO = 0; RDFIFO = 0;
    BWR = 0; H_WR = 0; H_RD = 0; SD_IN = 8'h00; H_DIN = 32'h0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    clear_inputs();
    $display("t=%0t cnt=%0d ni=%0d no=%0d bo=%0d", $time, m_cnt, m_ni, m_no, m_bo);
  endtask

  task automatic chk_state(input string tag, input int ni, input int no, input int bo, input int cnt);
    cmp({tag, "_ni"}, 32'(dut.ni_reg), 32'(ni));
    cmp({tag, "_no"}, 32'(dut.no_reg), 32'(no));
    cmp({tag, "_bo"}, 32'(dut.bo_reg), 32'(bo));
    cmp({tag, "_cnt"}, 32'(dut.count_reg), 32'(cnt));
  endtask

  logic [7:0] b35 [4];
  logic [7:0] b38 [4];

  initial begin
    b35 = '{8'h11, 8'h22, 8'h33, 8'h44};
    b38 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    clear_inputs();
    repeat (2) @(posedge CLK);
    #1;
    cmp("rst_empty", 32'(FIFOEMPTY), 32'd1);
    cmp("rst_full", 32'(FIFOFULL), 32'd0);
    cmp("rst_boeq3", 32'(BOEQ3), 32'd0);
    chk_state("rst", 0, 0, 0, 0);
    @(negedge CLK);
    nRESET = 1'b1;
    @(posedge CLK);
    #1;

    // Decrement at empty is ignored
    RDFIFO = 1; H_RD = 1; tick();
    chk_state("underflow", 0, 0, 0, 0);

    // Four SCSI bytes assemble one longword
    for (int i = 0; i < 4; i++) begin
      BWR = 1; INCBO = 1; SD_IN = b35[i];
      if (i == 3) begin
        RIFIFO = 1; INCNI = 1;
        cmp("bytes_boeq3", 32'(BOEQ3), 32'd1);
      end
      tick();
    end
    chk_state("bytes", 1, 0, 0, 1);
    cmp("bytes_hdout", H_DOUT, 32'h11223344);

    // INCNI and INCNO together both advance, count untouched
    INCNI = 1; INCNO = 1; tick();
    chk_state("incboth", 2, 1, 0, 1);
    FLUSH = 1; tick();
    chk_state("flush1", 0, 0, 0, 0);

    // Fill with host writes, then overflow attempt
    for (int i = 1; i <= 8; i++) begin
      H_WR = 1; H_DIN = 32'(i); tick();
    end
    cmp("fill_full", 32'(FIFOFULL), 32'd1);
    H_WR = 1; H_DIN = 32'h99; tick();
    chk_state("overflow", 0, 0, 0, 8);
    cmp("overflow_hdout", H_DOUT, 32'h00000001);

    // Read and write on a full FIFO
    H_RD = 1; H_WR = 1; H_DIN = 32'h09; tick();
    chk_state("rdwr_full", 1, 1, 0, 8);
    cmp("rdwr_hdout", H_DOUT, 32'h00000002);

    // Byte-serial drain of one longword
    FLUSH = 1; tick();
    H_WR = 1; H_DIN = 32'hAABBCCDD; tick();
    for (int i = 0; i < 4; i++) begin
      cmp("drain_sdout", 32'(SD_OUT), 32'(b38[i]));
      INCBO = 1;
      if (i == 3) begin
        RDFIFO = 1; INCNO = 1;
      end
      tick();
    end
    cmp("drain_empty", 32'(FIFOEMPTY), 32'd1);
    chk_state("drain", 1, 1, 0, 0);

    // Byte lane isolation and host-write priority over BWR
    FLUSH = 1; tick();
    H_WR = 1; H_DIN = 32'h01020304; tick();
    repeat (7) begin
      INCNI = 1; tick();
    end
    cmp("lane_ni", 32'(dut.ni_reg), 32'd0);
    INCBO = 1; tick();
    INCBO = 1; tick();
    BWR = 1; SD_IN = 8'hEE; tick();
    cmp("lane_hdout", H_DOUT, 32'h0102EE04);
    H_WR = 1; H_DIN = 32'h55667788; BWR = 1; SD_IN = 8'h99; tick();
    cmp("prio_hdout", H_DOUT, 32'h55667788);
    chk_state("prio", 1, 0, 2, 2);

    // FLUSH beats a simultaneous host write
    FLUSH = 1; tick();
    for (int i = 0; i < 5; i++) begin
      H_WR = 1; H_DIN = 32'h100 + 32'(i); tick();
    end
    INCBO = 1; tick();
    chk_state("pre_flush", 5, 0, 1, 5);
    FLUSH = 1; H_WR = 1; H_DIN = 32'hDEADBEEF; INCBO = 1; INCNI = 1; tick();
    chk_state("flush2", 0, 0, 0, 0);
    cmp("flush2_empty", 32'(FIFOEMPTY), 32'd1);

    // Asynchronous reset in the middle of a longword
    for (int i = 0; i < 3; i++) begin
      H_WR = 1; H_DIN = 32'h200 + 32'(i); tick();
    end
    INCBO = 1; tick();
    INCBO = 1; tick();
    chk_state("pre_rst", 3, 0, 2, 3);
    #2;
    nRESET = 1'b0;
    #1;
    chk_state("async_rst", 0, 0, 0, 0);
    cmp("async_empty", 32'(FIFOEMPTY), 32'd1);
    cmp("async_boeq3", 32'(BOEQ3), 32'd0);
    @(negedge CLK);
    nRESET = 1'b1;
    @(posedge CLK);
    #1;
    H_WR = 1; H_DIN = 32'hCAFEF00D; tick();
    chk_state("post_rst", 1, 0, 0, 1);
    cmp("post_rst_hdout", H_DOUT, 32'hCAFEF00D);

    repeat (2) @(posedge CLK);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
